// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode encodings, step constants, mode encoding and opcode-class helpers for the control sequencer.
package cpu_pkg;
  localparam int OPW = 5;
  localparam int STEPW = 3;
  localparam logic [OPW-1:0] OP_LDW = 5'd0, OP_LDWI = 5'd1, OP_STW = 5'd2, OP_ADD = 5'd3,
    OP_SUB = 5'd4, OP_SHR = 5'd5, OP_SHL = 5'd6, OP_ROR = 5'd7, OP_ROL = 5'd8, OP_AND = 5'd9,
    OP_OR = 5'd10, OP_ADDI = 5'd11, OP_ANDI = 5'd12, OP_ORI = 5'd13, OP_MUL = 5'd14,
    OP_DIV = 5'd15, OP_NEG = 5'd16, OP_NOT = 5'd17, OP_BR = 5'd18, OP_JR = 5'd19,
    OP_JAL = 5'd20, OP_IN = 5'd21, OP_OUT = 5'd22, OP_MFHI = 5'd23, OP_MFLO = 5'd24,
    OP_NOP = 5'd25, OP_HALT = 5'd26;
  localparam logic [STEPW-1:0] T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7;
  typedef enum logic [1:0] {M_RST, M_EXEC, M_HALT} mode_t;
  typedef struct packed {
    logic is_ld, is_ldi, is_st, is_alu3, is_imm, is_muldiv, is_unary, is_br;
    logic is_jr, is_jal, is_in, is_out, is_mf, is_nop, is_halt;
  } op_class_t;
  // Final step of each instruction; the step after it is always T0.
  function automatic logic [STEPW-1:0] last_step(op_class_t c);
    return (c.is_ld | c.is_st) ? T7 :
           (c.is_muldiv | c.is_br) ? T6 :
           (c.is_ldi | c.is_alu3 | c.is_imm) ? T5 :
           (c.is_unary | c.is_jal) ? T4 :
           (c.is_nop | c.is_halt) ? T2 : T3;
  endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: DataPath control bundle; mem_ready exists only when CU_MEM_WAIT_EN is defined.
interface control_sequencer_if;
  import cpu_pkg::*;
  logic [31:0] IR;
  logic CON_FF;
`ifdef CU_MEM_WAIT_EN
  logic mem_ready;
`endif
  logic PCout, Zlowout, Zhighout, HIout, LOout, MDRout, InPortout, Cout, BAout;
  logic Gra, Grb, Grc, Rin, Rout, R15in;
  logic MARin, MDRin, IRin, Yin, PCin, IncPC, Zin_low, Zin_high, HIin, LOin, CONin, OutPortin;
  logic Read, Write, Run;
  logic [OPW-1:0] operation;
  modport master (
    input IR, CON_FF,
`ifdef CU_MEM_WAIT_EN
    input mem_ready,
`endif
    output PCout, Zlowout, Zhighout, HIout, LOout, MDRout, InPortout, Cout, BAout,
    output Gra, Grb, Grc, Rin, Rout, R15in,
    output MARin, MDRin, IRin, Yin, PCin, IncPC, Zin_low, Zin_high, HIin, LOin, CONin, OutPortin,
    output Read, Write, Run, operation
  );
  modport slave (
    output IR, CON_FF,
`ifdef CU_MEM_WAIT_EN
    output mem_ready,
`endif
    input PCout, Zlowout, Zhighout, HIout, LOout, MDRout, InPortout, Cout, BAout,
    input Gra, Grb, Grc, Rin, Rout, R15in,
    input MARin, MDRin, IRin, Yin, PCin, IncPC, Zin_low, Zin_high, HIin, LOin, CONin, OutPortin,
    input Read, Write, Run, operation
  );
endinterface

// File: rtl/control_sequencer_decode.sv
// opcode_class_decode: maps IR[31:27] to one-hot instruction class flags.
module opcode_class_decode
  import cpu_pkg::*;
(
  input  logic [OPW-1:0] op,
  output op_class_t      cls
);
  always_comb begin
    cls.is_ld     = op == OP_LDW;
    cls.is_ldi    = op == OP_LDWI;
    cls.is_st     = op == OP_STW;
    cls.is_alu3   = op >= OP_ADD && op <= OP_OR;
    cls.is_imm    = op >= OP_ADDI && op <= OP_ORI;
    cls.is_muldiv = op == OP_MUL || op == OP_DIV;
    cls.is_unary  = op == OP_NEG || op == OP_NOT;
    cls.is_br     = op == OP_BR;
    cls.is_jr     = op == OP_JR;
    cls.is_jal    = op == OP_JAL;
    cls.is_in     = op == OP_IN;
    cls.is_out    = op == OP_OUT;
    cls.is_mf     = op == OP_MFHI || op == OP_MFLO;
    cls.is_nop    = op == OP_NOP || op > OP_HALT;
    cls.is_halt   = op == OP_HALT;
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute sequencer for the DataPath.
// Define CU_MEM_WAIT_EN to stretch memory steps until mem_ready.
module control_sequencer
  import cpu_pkg::*;
(
  input logic Clock,
  input logic clear,
  control_sequencer_if.master bus
);
  mode_t mode, nxt_mode;
  logic [STEPW-1:0] step, nxt_step;
  logic [OPW-1:0] op;
  op_class_t c;
  logic e, f0, f1, f2, x3, x4, x5, x6, x7, stall, unused_ir;
  assign op = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];
  opcode_class_decode u_dec (.op(op), .cls(c));
  assign e  = mode == M_EXEC;
  assign f0 = e && step == T0;
  assign f1 = e && step == T1;
  assign f2 = e && step == T2;
  assign x3 = e && step == T3;
  assign x4 = e && step == T4;
  assign x5 = e && step == T5;
  assign x6 = e && step == T6;
  assign x7 = e && step == T7;
`ifdef CU_MEM_WAIT_EN
  assign stall = (f1 | c.is_ld & x6 | c.is_st & x7) & ~bus.mem_ready;
`else
  assign stall = 1'b0;
`endif
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      mode <= M_RST;
      step <= T0;
    end else begin
      mode <= nxt_mode;
      step <= nxt_step;
    end
  end
  always_comb begin
    nxt_mode = mode;
    nxt_step = step;
    if (mode == M_RST) begin
      nxt_mode = M_EXEC;
      nxt_step = T0;
    end else if (e && !stall) begin
      nxt_mode = (step == T2 && c.is_halt) ? M_HALT : M_EXEC;
      nxt_step = (step == last_step(c)) ? T0 : step + STEPW'(1);
    end
  end
  // Address and branch-target adds in ldw/ldwi/stw/branch always run as ADD.
  always_comb begin
    bus.Run       = e;
    bus.operation = (e && step >= T3) ? ((c.is_ld | c.is_ldi | c.is_st | c.is_br) ? OP_ADD : op) : '0;
    bus.PCout     = f0 | c.is_jal & x3 | c.is_br & x4;
    bus.Zlowout   = f1 | (c.is_ld | c.is_ldi | c.is_st | c.is_alu3 | c.is_imm | c.is_muldiv) & x5
                  | c.is_unary & x4 | c.is_br & x6 & bus.CON_FF;
    bus.Zhighout  = c.is_muldiv & x6;
    bus.HIout     = c.is_mf & x3 & (op == OP_MFHI);
    bus.LOout     = c.is_mf & x3 & (op == OP_MFLO);
    bus.MDRout    = f2 | c.is_ld & x7;
    bus.InPortout = c.is_in & x3;
    bus.Cout      = (c.is_ld | c.is_ldi | c.is_st | c.is_imm) & x4 | c.is_br & x5;
    bus.BAout     = (c.is_ld | c.is_ldi | c.is_st) & x3;
    bus.Gra       = (c.is_ldi | c.is_alu3 | c.is_imm) & x5 | c.is_ld & x7 | c.is_st & x6
                  | (c.is_muldiv | c.is_br | c.is_jr | c.is_in | c.is_out | c.is_mf) & x3
                  | (c.is_unary | c.is_jal) & x4;
    bus.Grb       = (c.is_ld | c.is_ldi | c.is_st | c.is_alu3 | c.is_imm | c.is_unary) & x3
                  | c.is_muldiv & x4;
    bus.Grc       = c.is_alu3 & x4;
    bus.Rin       = (c.is_ldi | c.is_alu3 | c.is_imm) & x5 | c.is_ld & x7 | c.is_unary & x4
                  | (c.is_in | c.is_mf) & x3;
    bus.Rout      = c.is_st & x6
                  | (c.is_alu3 | c.is_imm | c.is_muldiv | c.is_unary | c.is_br | c.is_jr | c.is_out) & x3
                  | (c.is_alu3 | c.is_muldiv | c.is_jal) & x4;
    bus.R15in     = c.is_jal & x3;
    bus.MARin     = f0 | (c.is_ld | c.is_st) & x5;
    bus.MDRin     = f1 | (c.is_ld | c.is_st) & x6;
    bus.IRin      = f2;
    bus.Yin       = (c.is_ld | c.is_ldi | c.is_st | c.is_alu3 | c.is_imm | c.is_muldiv) & x3
                  | c.is_br & x4;
    bus.PCin      = f1 | c.is_br & x6 & bus.CON_FF | c.is_jr & x3 | c.is_jal & x4;
    bus.IncPC     = f0;
    bus.Zin_low   = f0 | (c.is_ld | c.is_ldi | c.is_st | c.is_alu3 | c.is_imm | c.is_muldiv) & x4
                  | c.is_unary & x3 | c.is_br & x5;
    bus.Zin_high  = c.is_muldiv & x4;
    bus.HIin      = c.is_muldiv & x6;
    bus.LOin      = c.is_muldiv & x5;
    bus.CONin     = c.is_br & x3;
    bus.OutPortin = c.is_out & x3;
    bus.Read      = f1 | c.is_ld & x6;
    bus.Write     = c.is_st & x7;
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of strobe patterns, latencies, reset abort and halt.
module tb_control_sequencer;
  logic Clock = 1'b0;
  logic clear = 1'b0;
  int total = 0;
  int bad = 0;
  logic [28:0] s;
  control_sequencer_if bus ();
  control_sequencer dut (.Clock(Clock), .clear(clear), .bus(bus));
  always #5 Clock = ~Clock;
  assign s = {bus.PCout, bus.Zlowout, bus.Zhighout, bus.HIout, bus.LOout, bus.MDRout,
              bus.InPortout, bus.Cout, bus.BAout, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
              bus.Rout, bus.R15in, bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.PCin,
              bus.IncPC, bus.Zin_low, bus.Zin_high, bus.HIin, bus.LOin, bus.CONin,
              bus.OutPortin, bus.Read, bus.Write};
  localparam logic [28:0] PCOUT = 29'd1 << 28, ZLOWOUT = 29'd1 << 27, ZHIGHOUT = 29'd1 << 26,
    HIOUT = 29'd1 << 25, LOOUT = 29'd1 << 24, MDROUT = 29'd1 << 23, INPORTOUT = 29'd1 << 22,
    COUT = 29'd1 << 21, BAOUT = 29'd1 << 20, GRA = 29'd1 << 19, GRB = 29'd1 << 18,
    GRC = 29'd1 << 17, RIN = 29'd1 << 16, ROUT = 29'd1 << 15, R15IN = 29'd1 << 14,
    MARIN = 29'd1 << 13, MDRIN = 29'd1 << 12, IRIN = 29'd1 << 11, YIN = 29'd1 << 10,
    PCIN = 29'd1 << 9, INCPC = 29'd1 << 8, ZINL = 29'd1 << 7, ZINH = 29'd1 << 6,
    HIIN = 29'd1 << 5, LOIN = 29'd1 << 4, CONIN = 29'd1 << 3, OUTPORTIN = 29'd1 << 2,
    READ = 29'd1 << 1, WRITE = 29'd1;
  localparam logic [28:0] FT0 = PCOUT | MARIN | INCPC | ZINL;
  localparam logic [28:0] FT1 = ZLOWOUT | PCIN | READ | MDRIN;
  localparam logic [28:0] FT2 = MDROUT | IRIN;
  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chs(input string tag, input logic [28:0] m);
    chk(tag, {3'b0, s}, {3'b0, m});
  endtask
  function automatic logic [31:0] ir(input logic [4:0] o);
    return {o, 27'd0};
  endfunction
  initial begin
    bus.IR = '0;
    bus.CON_FF = 1'b0;
`ifdef CU_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    #2;
    chs("rst_strobes", '0);
    chk("rst_run", 32'(bus.Run), 32'd0);
    chk("rst_op", 32'(bus.operation), 32'd0);
    tick(1);
    clear = 1'b1;
    tick(1);
    chs("first_t0", FT0);
    chk("first_run", 32'(bus.Run), 32'd1);
    bus.IR = 32'h08800007;
    tick(1); chs("ldwi_t1", FT1);
    tick(1); chs("ldwi_t2", FT2);
    tick(1); chs("ldwi_t3", GRB | BAOUT | YIN);
    tick(1); chs("ldwi_t4", COUT | ZINL);
    chk("ldwi_t4_op", 32'(bus.operation), 32'd3);
    tick(1); chs("ldwi_t5", ZLOWOUT | GRA | RIN);
    tick(1); chs("ldwi_done", FT0);
    bus.IR = ir(5'd0);
    tick(6); chs("ldw_t6", READ | MDRIN);
    tick(1); chs("ldw_t7", MDROUT | GRA | RIN);
    tick(1); chs("ldw_8cyc", FT0);
    tick(5); chs("ldw_t5", ZLOWOUT | MARIN);
    #2 clear = 1'b0;
    #1 chs("abort_strobes", '0);
    chk("abort_run", 32'(bus.Run), 32'd0);
    tick(1);
    clear = 1'b1;
    tick(1); chs("abort_t0", FT0);
    bus.IR = ir(5'd18);
    tick(3); chs("br0_t3", GRA | ROUT | CONIN);
    tick(2); chs("br0_t5", COUT | ZINL);
    chk("br0_t5_op", 32'(bus.operation), 32'd3);
    tick(1); chs("br0_t6", '0);
    tick(1); chs("br0_done", FT0);
    bus.CON_FF = 1'b1;
    tick(6); chs("br1_t6", ZLOWOUT | PCIN);
    tick(1); chs("br1_done", FT0);
    bus.CON_FF = 1'b0;
    bus.IR = ir(5'd14);
    tick(4); chs("mul_t4", GRB | ROUT | ZINL | ZINH);
    chk("mul_t4_op", 32'(bus.operation), 32'd14);
    tick(1); chs("mul_t5", ZLOWOUT | LOIN);
    tick(1); chs("mul_t6", ZHIGHOUT | HIIN);
    tick(1); chs("mul_done", FT0);
    bus.IR = ir(5'd2);
    tick(6); chs("stw_t6", GRA | ROUT | MDRIN);
    tick(1); chs("stw_t7", WRITE);
    tick(1); chs("stw_done", FT0);
    bus.IR = ir(5'd4) | 32'h0123_4567;
    tick(4); chs("sub_t4", GRC | ROUT | ZINL);
    chk("sub_t4_op", 32'(bus.operation), 32'd4);
    tick(1); chs("sub_t5", ZLOWOUT | GRA | RIN);
    tick(1); chs("sub_done", FT0);
    bus.IR = ir(5'd20);
    tick(3); chs("jal_t3", PCOUT | R15IN);
    tick(1); chs("jal_t4", GRA | ROUT | PCIN);
    tick(1); chs("jal_done", FT0);
    bus.IR = ir(5'd25);
    tick(2); chs("nop_t2", FT2);
    tick(1); chs("nop_done", FT0);
    bus.IR = ir(5'd31);
    tick(3); chs("rsvd_done", FT0);
`ifdef CU_MEM_WAIT_EN
    bus.IR = ir(5'd25);
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chs($sformatf("wait_read_%0d", i), FT1);
    end
    bus.mem_ready = 1'b1;
    tick(1); chs("wait_t2", FT2);
    tick(1); chs("wait_done", FT0);
`endif
    bus.IR = ir(5'd26);
    tick(2); chs("halt_t2", FT2);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chs($sformatf("halt_strobes_%0d", i), '0);
      chk($sformatf("halt_run_%0d", i), 32'(bus.Run), 32'd0);
    end
    clear = 1'b0;
    #2 clear = 1'b1;
    tick(1); chs("resume_t0", FT0);
    chk("resume_run", 32'(bus.Run), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
